tmds_decode: RTL and testbench

Receive-side TMDS channel decoder for the HDMI path. It takes one raw 10-bit parallel word per pixel clock from the deserializer, with arbitrary bit alignment, and finds the symbol boundary by searching for control tokens. It then decodes each aligned symbol back to 8-bit pixel data or to the c0/c1 sync pair and de. One instance sits behind each of the three TMDS data lanes.

---
 rtl/tmds_decode.sv | 229 ++++++++++++++++++++++
 tb/tb_tmds_decode.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decode.sv
// -----------------------------------------------------------------------------
// tmds_decode
//
// Receive-side TMDS channel decoder for one HDMI data lane. Raw 10-bit words
// from the deserializer arrive with arbitrary bit alignment. The block slides a
// 10-bit window across two consecutive words until it sees a run of control
// tokens at one offset. It then decodes each aligned symbol either to a pixel
// byte (de=1) or to the c1/c0 sync pair (de=0).
//
// Parameters
//   SEARCH_WIN  : cycles at one offset without a token before trying the next
//   LOCK_TOKENS : consecutive tokens at one offset needed to declare lock
//   LOSS_WIN    : token-free cycles in lock before lock is dropped
//
// Optional feature
//   TMDS_LOSS_DET_EN : when defined, lock drops after LOSS_WIN cycles without
//                      any control token. When undefined, only reset leaves lock.
//
// Ports
//   sys_clk    in   pixel clock
//   sys_rst_n  in   asynchronous active-low reset
//   data_in    in   [9:0] raw deserialized word, bit 0 received first
//   data_out   out  [7:0] decoded pixel byte (valid when de=1)
//   de         out  data enable
//   c0, c1     out  decoded hsync / vsync
//   locked     out  symbol alignment established
//   align_ofs  out  [3:0] current bit offset, 0..9
//
// Pipeline: prev -> aligned -> outputs. A symbol whose first bits are sampled
// at edge k appears on the outputs after edge k+2, whatever the offset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tmds_decode #(
  parameter int SEARCH_WIN  = 1024,
  parameter int LOCK_TOKENS = 8,
  parameter int LOSS_WIN    = 4096
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] data_in,
  output logic [7:0] data_out,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       locked,
  output logic [3:0] align_ofs
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [12:0] SEARCH_LAST = 13'(SEARCH_WIN - 1);
  localparam logic [12:0] LOSS_LAST   = 13'(LOSS_WIN - 1);
  localparam logic [3:0]  LOCK_LAST   = 4'(LOCK_TOKENS - 1);

`ifdef TMDS_LOSS_DET_EN
  localparam bit LOSS_DET = 1'b1;
`else
  localparam bit LOSS_DET = 1'b0;
`endif

  logic [9:0]  prev;
  logic [9:0]  aligned;
  logic [19:0] w;
  logic [1:0]  state;
  logic [3:0]  tok_cnt;
  logic [12:0] win_cnt;
  logic        skip;       // the aligned word was captured with the old offset

  logic        is_tok;
  logic [1:0]  tok_c;      // {c1,c0} carried by the token
  logic        tok_seen;   // token accepted by the FSM
  logic [7:0]  d;
  logic [7:0]  q;

  logic [1:0]  state_nx;
  logic [3:0]  ofs_nx;
  logic [3:0]  ofs_inc;
  logic [3:0]  tok_nx;
  logic [3:0]  tok_inc;
  logic [12:0] win_nx;
  logic        ofs_chg;
  logic        locked_nx;

  // Older bits sit in the LSBs, so a symbol straddling two words is read out
  // contiguously starting at align_ofs.
  assign w = {data_in, prev};

  // ---------------------------------------------------------------------------
  // Symbol classification and data decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (aligned)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then undo the XOR / XNOR transition chain.
  always_comb begin
    d    = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = aligned[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------------
  assign tok_seen = is_tok & ~skip;
  assign ofs_inc  = (align_ofs == 4'd9) ? 4'd0 : align_ofs + 4'd1;
  assign tok_inc  = (tok_cnt == 4'hF) ? tok_cnt : tok_cnt + 4'd1;

  always_comb begin
    state_nx = state;
    ofs_nx   = align_ofs;
    tok_nx   = tok_cnt;
    win_nx   = win_cnt;
    ofs_chg  = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (tok_seen) begin
          state_nx = ST_VERIFY;
          tok_nx   = 4'd1;
          win_nx   = '0;
        end else if (win_cnt == SEARCH_LAST) begin
          ofs_nx  = ofs_inc;
          win_nx  = '0;
          ofs_chg = 1'b1;
        end else begin
          win_nx = win_cnt + 13'd1;
        end
      end
      ST_VERIFY: begin
        if (tok_seen) begin
          tok_nx = tok_inc;
          win_nx = '0;
          if (tok_cnt >= LOCK_LAST) state_nx = ST_LOCKED;
        end else begin
          // One data word at a candidate offset disproves it.
          state_nx = ST_SEARCH;
          ofs_nx   = ofs_inc;
          tok_nx   = '0;
          win_nx   = '0;
          ofs_chg  = 1'b1;
        end
      end
      ST_LOCKED: begin
        tok_nx = tok_seen ? tok_inc : 4'd0;
        if (tok_seen || !LOSS_DET) begin
          win_nx = '0;
        end else if (win_cnt == LOSS_LAST) begin
          // Offset is kept: the link most likely came back at the same phase.
          state_nx = ST_SEARCH;
          tok_nx   = '0;
          win_nx   = '0;
        end else begin
          win_nx = win_cnt + 13'd1;
        end
      end
      default: begin
        state_nx = ST_SEARCH;
        tok_nx   = '0;
        win_nx   = '0;
      end
    endcase
  end

  // Outputs follow the lock state that takes effect on the same edge.
  assign locked_nx = (state_nx == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev      <= '0;
      aligned   <= '0;
      state     <= ST_SEARCH;
      align_ofs <= '0;
      tok_cnt   <= '0;
      win_cnt   <= '0;
      skip      <= 1'b0;
      locked    <= 1'b0;
      de        <= 1'b0;
      data_out  <= '0;
      c0        <= 1'b0;
      c1        <= 1'b0;
    end else begin
      prev      <= data_in;
      aligned   <= w[align_ofs +: 10];
      state     <= state_nx;
      align_ofs <= ofs_nx;
      tok_cnt   <= tok_nx;
      win_cnt   <= win_nx;
      skip      <= ofs_chg;
      locked    <= locked_nx;
      if (!locked_nx) begin
        de       <= 1'b0;
        data_out <= '0;
        c0       <= 1'b0;
        c1       <= 1'b0;
      end else if (is_tok) begin
        de       <= 1'b0;
        data_out <= '0;
        c1       <= tok_c[1];
        c0       <= tok_c[0];
      end else begin
        // Sync values persist through the active video region.
        de       <= 1'b1;
        data_out <= q;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decode.sv
// -----------------------------------------------------------------------------
// tb_tmds_decode
//
// Self-checking bench for tmds_decode. Symbols are serialized into a bit queue
// (optionally preceded by filler bits to shift the symbol boundary) and popped
// ten bits per clock into data_in. Expected outputs for each symbol are queued
// alongside and compared two edges after the symbol's first bits are sampled.
// Pixel data is produced by a full TMDS encoder with running disparity, so the
// decoded byte is checked against the original byte rather than a decode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tmds_decode;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam int LOCK_TOKENS = 8;
  localparam int SEARCH_WIN  = 1024;
  localparam int LOSS_WIN    = 4096;

  typedef struct packed {
    logic [9:0]  word;
    logic [10:0] outs;   // {de, data_out, c1, c0}
  } vec_t;

  typedef struct packed {
    logic        chk;
    logic [10:0] outs;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [9:0] data_in;
  logic [7:0] data_out;
  logic       de;
  logic       c0;
  logic       c1;
  logic       locked;
  logic [3:0] align_ofs;

  int   n_cmp;
  int   n_bad;
  int   rd;                 // encoder running disparity
  bit   bq[$];
  exp_t eq[$];
  exp_t nochk;
  logic [9:0] toks [4];
  vec_t tbl [12];

  tmds_decode dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data_in   (data_in),
    .data_out  (data_out),
    .de        (de),
    .c0        (c0),
    .c1        (c1),
    .locked    (locked),
    .align_ofs (align_ofs)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one symbol into the serial stream, clock one word into the DUT and
  // compare the symbol that was pushed two edges earlier.
  task automatic step(input string name, input logic [9:0] sym, input exp_t e);
    logic [9:0] wd;
    exp_t f;
    for (int i = 0; i < 10; i++) bq.push_back(sym[i]);
    for (int i = 0; i < 10; i++) wd[i] = bq.pop_front();
    data_in = wd;
    eq.push_back(e);
    @(posedge sys_clk);
    #1;
    if (eq.size() > 2) begin
      f = eq.pop_front();
      if (f.chk) check(name, {21'd0, de, data_out, c1, c0}, {21'd0, f.outs});
    end
  endtask

  task automatic do_reset(input int fill);
    sys_rst_n = 1'b0;
    data_in   = '0;
    bq.delete();
    eq.delete();
    for (int i = 0; i < fill; i++) bq.push_back(1'b0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_state", {16'd0, locked, align_ofs, de, data_out, c1, c0}, 32'd0);
    sys_rst_n = 1'b1;
  endtask

  function automatic int ones8(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // Standard DVI/TMDS 8b/10b data encoder with running disparity.
  task automatic tmds_encode(input logic [7:0] b, output logic [9:0] sym);
    logic [8:0] qm;
    bit         use_xnor;
    int         n1;
    int         n0;
    use_xnor = (ones8(b) > 4) || (ones8(b) == 4 && b[0] == 1'b0);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    n1 = ones8(qm[7:0]);
    n0 = 8 - n1;
    if (rd == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) rd += n1 - n0;
      else       rd += n0 - n1;
    end else if ((rd > 0 && n1 > n0) || (rd < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      rd += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      rd += -2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  initial begin
    exp_t        e;
    logic [9:0]  sym;
    logic [7:0]  b;
    logic [1:0]  mc;
    int          k;
    int          first_ofs1;
    bit          got;

    n_cmp = 0;
    n_bad = 0;
    rd    = 0;
    nochk = '0;
    sys_rst_n = 1'b0;
    data_in   = '0;

    toks[0] = 10'b1101010100;
    toks[1] = 10'b0010101011;
    toks[2] = 10'b0101010100;
    toks[3] = 10'b1010101011;

    // Locked decode vectors: tokens, then encoded bytes in both chain modes,
    // plain and inverted. Data words keep the sync pair of the prior token.
    tbl[0]  = '{10'h2AB, {1'b0, 8'h00, 2'b11}};
    tbl[1]  = '{10'h100, {1'b1, 8'h00, 2'b11}};
    tbl[2]  = '{10'h3FF, {1'b1, 8'h00, 2'b11}};
    tbl[3]  = '{10'h0AB, {1'b0, 8'h00, 2'b01}};
    tbl[4]  = '{10'h0FF, {1'b1, 8'hFF, 2'b01}};
    tbl[5]  = '{10'h200, {1'b1, 8'hFF, 2'b01}};
    tbl[6]  = '{10'h154, {1'b0, 8'h00, 2'b10}};
    tbl[7]  = '{10'h1F0, {1'b1, 8'h10, 2'b10}};
    tbl[8]  = '{10'h30F, {1'b1, 8'h10, 2'b10}};
    tbl[9]  = '{10'h354, {1'b0, 8'h00, 2'b00}};
    tbl[10] = '{10'h163, {1'b1, 8'hA5, 2'b00}};
    tbl[11] = '{10'h39C, {1'b1, 8'hA5, 2'b00}};

    // ---- Lock at offset 0: the 8th token is judged at edge 9 ----
    do_reset(0);
    for (int n = 0; n < 10; n++) begin
      step("lock0", T00, nochk);
      if (n == 8) check("lock0_not_yet", {31'd0, locked}, 32'd0);
      if (n == 9) check("lock0_state", {16'd0, locked, align_ofs, de, data_out, c1, c0},
                        {16'd0, 1'b1, 4'd0, 1'b0, 8'h00, 2'b00});
    end
    repeat (3) step("lock0_hold", T00, nochk);

    // ---- Table-driven decode while locked ----
    for (int i = 0; i < 12; i++) step($sformatf("tbl%0d", i), tbl[i].word, '{1'b1, tbl[i].outs});
    repeat (2) step("tbl_flush", 10'h100, nochk);

    // ---- Asynchronous reset while locked, then relock ----
    check("pre_reset_de", {30'd0, locked, de}, 32'd3);
    sys_rst_n = 1'b0;
    #1;
    check("async_reset", {16'd0, locked, align_ofs, de, data_out, c1, c0}, 32'd0);
    bq.delete();
    eq.delete();
    data_in = '0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    got = 0;
    for (int n = 0; n < LOCK_TOKENS + 2 && !got; n++) begin
      step("relock", T00, nochk);
      if (locked) got = 1;
    end
    check("relock", {31'd0, got}, 32'd1);

    // ---- Data word in VERIFY after 5 tokens ----
    do_reset(0);
    for (int n = 0; n < 5; n++) step("verify", T00, nochk);
    step("verify", 10'h100, nochk);
    step("verify", T00, nochk);
    check("verify_still_ofs0", {28'd0, align_ofs}, 32'd0);
    step("verify", T00, nochk);
    check("verify_abort", {27'd0, locked, align_ofs}, {27'd0, 1'b0, 4'd1});
    for (int n = 0; n < 20; n++) step("verify", T00, nochk);
    check("verify_no_lock", {31'd0, locked}, 32'd0);

    // ---- Long data-only run after lock ----
    do_reset(0);
    for (int n = 0; n < 10; n++) step("loss_lock", T00, nochk);
    check("loss_locked", {31'd0, locked}, 32'd1);
    for (int j = 0; j <= LOSS_WIN + 1; j++) begin
      step("loss", 10'h100, nochk);
      if (j == LOSS_WIN) check("loss_before", {30'd0, locked, de}, 32'd3);
    end
`ifdef TMDS_LOSS_DET_EN
    check("loss_after", {27'd0, locked, de, 3'd0} | {28'd0, align_ofs}, 32'd0);
`else
    check("loss_after", {27'd0, locked, de, 3'd0} | {28'd0, align_ofs}, 32'h18);
`endif

    // ---- Stream shifted by 3 bits, T11 tokens ----
    do_reset(3);
    first_ofs1 = -1;
    got = 0;
    for (int n = 0; n < 5 * SEARCH_WIN && !got; n++) begin
      step("search", T11, nochk);
      if (first_ofs1 < 0 && align_ofs == 4'd1) first_ofs1 = n;
      if (locked) got = 1;
    end
    check("search_dwell", first_ofs1, SEARCH_WIN - 1);
    check("lock_ofs3", {31'd0, got}, 32'd1);
    check("ofs3_state", {16'd0, align_ofs, de, data_out, c1, c0},
          {16'd0, 1'b0, 4'd3, 1'b0, 8'h00, 2'b11});

    // ---- Random tokens and encoded bytes at offset 3 ----
    mc = 2'b11;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        k   = $urandom_range(3);
        sym = toks[k];
        mc  = k[1:0];
        e   = '{1'b1, {1'b0, 8'h00, mc}};
      end else begin
        b = 8'($urandom);
        tmds_encode(b, sym);
        e = '{1'b1, {1'b1, b, mc}};
      end
      step("random", sym, e);
    end
    repeat (2) step("rand_flush", T11, nochk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
